// File: rtl/dec_display_if.sv
// Handshake and display bundle between the register-file read side (master)
// and the seven-segment driver (slave).
interface dec_display_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
);
  logic [WIDTH-1:0]    value;
  logic                update;
  logic                hex_mode;
  logic                busy;
  logic                done;
  logic                overflow;
  logic [DIGITS*7-1:0] seg;

  modport master (
    output value, update, hex_mode,
    input  busy, done, overflow, seg
  );

  modport slave (
    input  value, update, hex_mode,
    output busy, done, overflow, seg
  );
endinterface

// File: rtl/dec_display_driver.sv
// Sequential binary-to-seven-segment driver using a bit-serial double-dabble engine.
// Optional macro LEADING_ZERO_BLANK_EN blanks decimal leading zeros.
module dec_display_driver #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8,
  parameter int SIGNED = 1
) (
  input  logic        clk,
  input  logic        rst,
  dec_display_if.slave bus,
  output logic [1:0]  fsm_state
);

  // Handshake: update is taken only in IDLE (busy=0) and is then ignored until
  // done pulses; done marks the single cycle in which new segments first show,
  // and an update in that same cycle is accepted.
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

  localparam int BCD_MIN = WIDTH / 3 + 1;
  localparam int BCD_D   = (BCD_MIN > DIGITS) ? BCD_MIN : DIGITS;
  localparam int CW      = $clog2(WIDTH);
  localparam int BW      = 4 * BCD_D;

  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'h0: r = 7'b0000001;
      4'h1: r = 7'b1001111;
      4'h2: r = 7'b0010010;
      4'h3: r = 7'b0000110;
      4'h4: r = 7'b1001100;
      4'h5: r = 7'b0100100;
      4'h6: r = 7'b0100000;
      4'h7: r = 7'b0001111;
      4'h8: r = 7'b0000000;
      4'h9: r = 7'b0001100;
      4'hA: r = 7'b0001000;
      4'hB: r = 7'b1100000;
      4'hC: r = 7'b0110001;
      4'hD: r = 7'b1000010;
      4'hE: r = 7'b0110000;
      default: r = 7'b0111000;
    endcase
    return r;
  endfunction

  function automatic logic [DIGITS*7-1:0] reset_pattern();
    logic [DIGITS*7-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      if (SIGNED != 0 && i == DIGITS - 1) r[7*i +: 7] = SEG_BLANK;
      else                                r[7*i +: 7] = seg7(4'h0);
    end
    return r;
  endfunction

  localparam logic [DIGITS*7-1:0] RESET_SEG = reset_pattern();

  // One double-dabble step: correct every nibble >=5, then shift in the next bit.
  function automatic logic [BW-1:0] dabble(input logic [BW-1:0] a, input logic b);
    logic [BW-1:0] r;
    r = a;
    for (int i = 0; i < BCD_D; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return {r[BW-2:0], b};
  endfunction

  state_t              state;
  logic [WIDTH-1:0]    val_q;
  logic                hex_q;
  logic [WIDTH-1:0]    mag;
  logic [BW-1:0]       acc;
  logic [CW-1:0]       cnt;
  logic                sign_q;
  logic [DIGITS*7-1:0] seg_q;
  logic                ovf_q;
  logic                busy_q;
  logic                done_q;

  logic [DIGITS*7-1:0]        seg_next;
  logic                       ovf_next;
  logic [WIDTH+4*DIGITS-1:0]  wide;
  int                         n_dig;
`ifdef LEADING_ZERO_BLANK_EN
  int                         msd;
`endif

  always_comb begin
    seg_next = '0;
    ovf_next = 1'b0;
    wide     = {{(4*DIGITS){1'b0}}, val_q};
    n_dig    = (SIGNED != 0 && !hex_q) ? DIGITS - 1 : DIGITS;
`ifdef LEADING_ZERO_BLANK_EN
    msd = 0;
    for (int i = 0; i < BCD_D; i++) begin
      if (acc[4*i +: 4] != 4'd0) msd = i;
    end
`endif
    if (hex_q) begin
      ovf_next = |wide[WIDTH+4*DIGITS-1:4*DIGITS];
    end else begin
      for (int i = 0; i < BCD_D; i++) begin
        if (i >= n_dig && acc[4*i +: 4] != 4'd0) ovf_next = 1'b1;
      end
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (i < n_dig) begin
        if (hex_q)         seg_next[7*i +: 7] = seg7(wide[4*i +: 4]);
        else if (ovf_next) seg_next[7*i +: 7] = SEG_E;
`ifdef LEADING_ZERO_BLANK_EN
        else if (i > msd)  seg_next[7*i +: 7] = SEG_BLANK;
`endif
        else               seg_next[7*i +: 7] = seg7(acc[4*i +: 4]);
      end else begin
        // Only reachable for the reserved top digit in signed decimal mode.
        seg_next[7*i +: 7] = sign_q ? SEG_MINUS : SEG_BLANK;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      val_q  <= '0;
      hex_q  <= 1'b0;
      mag    <= '0;
      acc    <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      seg_q  <= RESET_SEG;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.update) begin
            val_q  <= bus.value;
            hex_q  <= bus.hex_mode;
            busy_q <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          acc <= '0;
          if (!hex_q && SIGNED != 0 && val_q[WIDTH-1]) begin
            mag    <= -val_q;
            sign_q <= 1'b1;
          end else begin
            mag    <= val_q;
            sign_q <= 1'b0;
          end
          if (hex_q) begin
            state <= LATCH;
          end else begin
            cnt   <= CW'(WIDTH - 1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= dabble(acc, mag[WIDTH-1]);
          mag <= mag << 1;
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= LATCH;
        end
        LATCH: begin
          seg_q  <= seg_next;
          ovf_q  <= ovf_next;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.seg      = seg_q;
  assign fsm_state    = state;

endmodule

// File: tb/tb_dec_display_driver.sv
// Self-checking bench for dec_display_driver with default parameters (32-bit, 8 digits, signed).
module tb_dec_display_driver;
  localparam int WIDTH  = 32;
  localparam int DIGITS = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] fsm_state;

  dec_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  dec_display_driver #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SIGNED(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [DIGITS*7-1:0] exp_q[$];
  logic                exp_ovf_q[$];

  localparam logic [55:0] RESET_SEG = {7'b1111111, {7{7'b0000001}}};

  function automatic logic [6:0] seg_code(input int d);
    case (d)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      9: return 7'b0001100;  10: return 7'b0001000; 11: return 7'b1100000;
      12: return 7'b0110001; 13: return 7'b1000010; 14: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  // Reference model: plain division for decimal, nibble slicing for hex.
  function automatic logic [55:0] model(input logic [31:0] v, input logic h, output logic ovf);
    logic [55:0] s;
    logic [31:0] m;
    logic        neg;
    longint      mm;
    s = '0;
    if (h) begin
      ovf = 1'b0;
      for (int i = 0; i < 8; i++) s[7*i +: 7] = seg_code(int'(v[4*i +: 4]));
    end else begin
      neg = v[31];
      m   = neg ? (~v + 32'd1) : v;
      mm  = longint'(m);
      ovf = (mm > 64'd9999999);
      for (int i = 0; i < 7; i++) begin
        if (ovf) s[7*i +: 7] = 7'b0110000;
`ifdef LEADING_ZERO_BLANK_EN
        else if (i > 0 && mm == 0) s[7*i +: 7] = 7'b1111111;
`endif
        else s[7*i +: 7] = seg_code(int'(mm % 10));
        mm = mm / 10;
      end
      s[49 +: 7] = neg ? 7'b1111110 : 7'b1111111;
    end
    return s;
  endfunction

  task automatic issue(input logic [31:0] v, input logic h, input bit track);
    logic [55:0] s;
    logic        o;
    bus.value    = v;
    bus.hex_mode = h;
    bus.update   = 1'b1;
    if (track) begin
      s = model(v, h, o);
      exp_q.push_back(s);
      exp_ovf_q.push_back(o);
    end
    @(posedge clk); #1;
    bus.update = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_err++; $display("FAIL busy_on_accept: got %b want 1", bus.busy);
    end
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++; $display("FAIL done_after_accept: got %b want 0", bus.done);
    end
  endtask

  task automatic await_done(input int lat, input string name);
    int k;
    bit seen;
    logic [55:0] es;
    logic        eo;
    seen = 0;
    for (k = 1; k <= lat + 8; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        seen = 1;
        break;
      end
      if (bus.busy !== 1'b1) begin
        n_cmp++; n_err++; $display("FAIL %s_busy: got %b want 1 at edge %0d", name, bus.busy, k);
      end
    end
    n_cmp++;
    if (!seen || k != lat) begin
      n_err++; $display("FAIL %s_latency: got %0d want %0d (seen=%0d)", name, k, lat, seen);
    end
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++; $display("FAIL %s_scoreboard: got empty queue want one entry", name);
      return;
    end
    es = exp_q.pop_front();
    eo = exp_ovf_q.pop_front();
    if (!seen) return;
    n_cmp++;
    if (bus.seg !== es) begin
      n_err++; $display("FAIL %s_seg: got %h want %h", name, bus.seg, es);
    end
    n_cmp++;
    if (bus.overflow !== eo) begin
      n_err++; $display("FAIL %s_overflow: got %b want %b", name, bus.overflow, eo);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL %s_busy_end: got %b want 0", name, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_cmp++;
    if (bus.seg !== RESET_SEG) begin n_err++; $display("FAIL reset_seg: got %h want %h", bus.seg, RESET_SEG); end
    n_cmp++;
    if ({bus.busy, bus.done, bus.overflow} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.done, bus.overflow});
    end
    #4 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_decimal_pos();
    issue(32'd12345, 1'b0, 1'b1);
    bus.value = 32'hFFFF_0000;  // must not disturb the captured value
    await_done(WIDTH + 2, "dec_pos");
    n_cmp++;
    if (bus.seg[34:0] !== {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100}) begin
      n_err++; $display("FAIL dec_pos_low_digits: got %h want 12345 pattern", bus.seg[34:0]);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.done !== 1'b0) begin n_err++; $display("FAIL dec_pos_done_width: got %b want 0", bus.done); end
  endtask

  task automatic test_decimal_neg();
    issue(32'hFFFF_FFF9, 1'b0, 1'b1);
    await_done(WIDTH + 2, "dec_neg");
  endtask

  task automatic test_overflow();
    issue(32'h8000_0000, 1'b0, 1'b1);
    await_done(WIDTH + 2, "overflow_min");
    issue(32'd10000000, 1'b0, 1'b1);
    await_done(WIDTH + 2, "overflow_edge");
    issue(32'd9999999, 1'b0, 1'b1);
    await_done(WIDTH + 2, "fit_edge");
  endtask

  task automatic test_hex();
    issue(32'hDEAD_BEEF, 1'b1, 1'b1);
    bus.value  = 32'h1234_5678;
    bus.update = 1'b1;  // arrives while busy: must be dropped
    @(posedge clk); #1;
    bus.update = 1'b0;
    await_done(1, "hex");
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_cmp++; n_err++; $display("FAIL hex_ignored_update: got busy=%b done=%b want 0 0", bus.busy, bus.done);
      end
    end
    n_cmp++;
    if (fsm_state !== 2'd0) begin n_err++; $display("FAIL hex_idle_state: got %0d want 0", fsm_state); end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    issue(32'd12345, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.seg !== RESET_SEG) begin n_err++; $display("FAIL midrst_seg: got %h want %h", bus.seg, RESET_SEG); end
    n_cmp++;
    if ({bus.busy, bus.done, bus.overflow} !== 3'b000) begin
      n_err++; $display("FAIL midrst_flags: got %b want 000", {bus.busy, bus.done, bus.overflow});
    end
    #2 rst = 1'b0;
    saw_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) saw_done = 1;
    end
    n_cmp++;
    if (saw_done) begin n_err++; $display("FAIL midrst_no_done: got 1 want 0"); end
    issue(32'd42, 1'b0, 1'b1);
    await_done(WIDTH + 2, "after_reset");
  endtask

  task automatic test_back_to_back();
    issue(32'd7, 1'b0, 1'b1);
    await_done(WIDTH + 2, "b2b_first");
    issue(32'h0000_00A5, 1'b1, 1'b1);  // taken in the done cycle
    await_done(2, "b2b_second");
    issue(32'd0, 1'b0, 1'b1);
    await_done(WIDTH + 2, "b2b_zero");
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic        h;
    for (int i = 0; i < 12; i++) begin
      v = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 99999)) : 32'($urandom);
      h = 1'($urandom_range(0, 1));
      issue(v, h, 1'b1);
      await_done(h ? 2 : WIDTH + 2, "random");
    end
  endtask

  initial begin
    bus.value    = '0;
    bus.update   = 1'b0;
    bus.hex_mode = 1'b0;
    test_reset();
    test_decimal_pos();
    test_decimal_neg();
    test_overflow();
    test_hex();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dec_display_driver.md
Name: dec_display_driver

Overview:
- Sequential binary-to-seven-segment display driver for the board HEX digits; parametrised successor to the processor's fixed 7-digit decimal display logic.
- Converts a WIDTH-bit register value to DIGITS segment patterns using a one-bit-per-cycle shift-add-3 (double-dabble) engine instead of combinational divide/modulo.
- Adds a start/busy/done handshake, overflow detection and a hex display mode.
- Sits between the register file read port and the HEX outputs at the processor top level.

Parameters:
- WIDTH, 32, bit width of the input value (4..32).
- DIGITS, 8, number of seven-segment digits driven (2..8).
- SIGNED, 1, 1: value is two's complement and digit DIGITS-1 is reserved for the sign; 0: value is unsigned and all digits are numeric.

Ports:
- clk  input  1  system clock, all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- value  input  WIDTH  number to display; sampled only on an accepted update.
- update  input  1  start request; accepted only in IDLE.
- hex_mode  input  1  sampled with value; 1 selects hex display, 0 selects decimal.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new segment patterns become visible.
- overflow  output  1  high when the last displayed value did not fit in the available digits.
- seg  output  DIGITS*7  segment patterns; digit i occupies seg[7i+6:7i], bit 6 = segment a … bit 0 = segment g; active-low.

Behaviour:
- Reset (asynchronous, immediate, even mid-conversion):
  - busy=0, done=0, overflow=0, FSM=IDLE.
  - Numeric digits show "0" (0000001).
  - When SIGNED=1, digit DIGITS-1 is blank (1111111).
- Segment codes:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100.
  - A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - Minus=1111110, blank=1111111.
- FSM states: IDLE, LOAD, SHIFT, LATCH.
- IDLE:
  - If update=1 at a posedge: capture value and hex_mode, busy goes high, go to LOAD.
  - update=0: stay in IDLE.
- LOAD (1 cycle):
  - Decimal mode with SIGNED=1 and value[WIDTH-1]=1: magnitude = two's-complement negation as an unsigned WIDTH-bit quantity (so -2^(WIDTH-1) gives magnitude 2^(WIDTH-1)) and the sign flag is set.
  - Otherwise: magnitude = value and the sign flag is clear.
  - Clear the BCD accumulator, which holds at least WIDTH/3+1 digits.
  - Hex mode: go to LATCH. Decimal mode: go to SHIFT with the bit counter = WIDTH-1.
- SHIFT (exactly WIDTH cycles):
  - Each cycle, every BCD nibble ≥5 has 3 added, then the accumulator shifts left by one, taking in the magnitude MSB.
  - When the counter reaches 0, go to LATCH.
- LATCH (1 cycle):
  - Segments, overflow and the sign digit update on this edge; done=1 for the following cycle; busy=0; go to IDLE.
- Numeric digits N = DIGITS-1 when SIGNED=1 and in decimal mode; otherwise N = DIGITS.
- Overflow rule:
  - Decimal mode: any BCD digit at index ≥N is nonzero.
  - Hex mode: any value bit at index ≥4·DIGITS is nonzero.
  - On overflow: overflow=1, all N numeric digits show E, and the sign digit still reflects the sign flag.
- Hex mode:
  - Unsigned; shows all DIGITS digits of value[4·DIGITS-1:0], digit i = nibble i.
  - The SIGNED parameter has no effect in hex mode.
- Sign digit (SIGNED=1, decimal mode): minus when the sign flag is set, else blank.
- Latency from the update-accepting edge E to the segment-update edge:
  - Decimal: WIDTH+2 edges (edge 34 for WIDTH=32).
  - Hex: 2 edges.
  - done is high during the cycle after that edge.
- update while busy: ignored, not queued.
- An update seen in the same cycle that done is high is accepted, since the FSM is already in IDLE.
- seg, overflow and the sign digit hold their values between conversions.
- Only the captured copy of value is used; changes to value during a conversion have no effect.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - In decimal mode without overflow, numeric digits above the most significant nonzero digit show blank; digit 0 always shows, so the value 0 displays "0".
  - The minus sign stays in the fixed top digit.
  - Hex mode is unaffected.
- Undefined: all numeric digits are always shown, including leading zeros.

Test Plan:
- Reset: assert rst with no clock → seg digits 0..6 = 0000001, digit 7 = 1111111; busy=0, done=0, overflow=0.
- Decimal positive (defaults), value=12345, update at edge 0:
  - busy=1 from edge 0; at edge 34 digits 0..4 = 5,4,3,2,1, digits 5..6 = 0, digit 7 blank.
  - done high for exactly one cycle; overflow=0.
- Decimal negative: value=0xFFFFFFF9 (-7) → digit 0 = 0001111, digits 1..6 = 0000001, digit 7 = 1111110.
- Overflow: value=0x80000000 (SIGNED) → overflow=1, digits 0..6 = 0110000, digit 7 = minus.
- Hex mode: value=0xDEADBEEF, hex_mode=1 → segments update at edge 2 with digits 0..7 = F,E,E,b,d,A,E,d; overflow=0.
  - A second update pulse at edge 1 is ignored.
- Reset mid-conversion: rst pulse at edge 10 of a decimal conversion → immediate reset outputs and no done pulse.
  - A following update with value=42 displays 2,4 at edge 34 after it is accepted.
